// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
// Build option: TIMER_RESTART_EN lets start re-arm a busy timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_DEF     = 10;
  localparam int unsigned PRESC_DIV_DEF = 5;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between register logic and the timer.
// The register side is the master, the timer is the slave.
interface timer_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             stop;
  logic             mode;
  logic             updn;
  logic [WIDTH-1:0] period;
  logic             irq_clr;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             done;
  logic             irq;

  modport master (
    output start, stop, mode, updn,
    output period, irq_clr,
    input  busy, cnt, done, irq
  );

  modport slave (
    input  start, stop, mode, updn,
    input  period, irq_clr,
    output busy, cnt, done, irq
  );
endinterface

// File: rtl/cnt_updn.sv
// Loadable up/down binary counter; load has priority over enable.
module cnt_updn
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             updn_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = data_in_i;
    end else if (en_i) begin
      cnt_d = (updn_i == DOWN) ? cnt_q - ONE
                               : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/timer_ctrl.sv
// Interval timer sequencer: FSM, prescaler, terminal detect, irq.
// Build option: TIMER_RESTART_EN allows restart while busy.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int PRESC_DIV = PRESC_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  timer_ctrl_if.slave bus
);

  localparam int PW =
    (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC_DIV - 1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             updn_q, updn_d;
  logic             irq_q, irq_d;

  logic             start_acc;
  logic             restart;
  logic             tick;
  logic             term;
  logic             busy;
  logic             ld;
  logic             en;
  logic             done;
  logic             latch;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] start_val;

  assign start_acc = bus.start & ~bus.stop;

`ifdef TIMER_RESTART_EN
  assign restart = start_acc & (state_q != IDLE);
`else
  assign restart = 1'b0;
`endif

  assign tick = (state_q == RUN) && (presc_q == PLAST);
  assign start_val = (updn_q == DOWN) ? per_q : '0;
  assign term = (updn_q == DOWN) ? (cnt == '0)
                                 : (cnt == per_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      updn_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      updn_q  <= updn_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_acc) state_d = LOAD;
      LOAD: begin
        if (bus.stop)     state_d = IDLE;
        else if (restart) state_d = LOAD;
        else              state_d = RUN;
      end
      RUN: begin
        if (bus.stop)     state_d = IDLE;
        else if (restart) state_d = LOAD;
        else if (tick && term && mode_q == ONESHOT)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    latch = start_acc && ((state_q == IDLE) || restart);
    ld    = 1'b0;
    en    = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      LOAD: ld = !bus.stop && !restart;
      RUN: begin
        // stop and restart both outrank the tick
        if (tick && !bus.stop && !restart) begin
          if (term) begin
            done = 1'b1;
            ld   = (mode_q == PERIODIC);
          end else begin
            en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    presc_d = '0;
    if (state_q == RUN)
      presc_d = tick ? '0 : presc_q + PONE;
    per_d  = latch ? bus.period : per_q;
    mode_d = latch ? bus.mode   : mode_q;
    updn_d = latch ? bus.updn   : updn_q;
    irq_d  = done ? 1'b1 : (bus.irq_clr ? 1'b0 : irq_q);
  end

  cnt_updn #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ld),
    .en_i     (en),
    .updn_i   (updn_q),
    .data_in_i(start_val),
    .cnt_o    (cnt)
  );

  assign bus.busy = busy;
  assign bus.cnt  = cnt;
  assign bus.done = done;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus a random run
// checked against a tick-arithmetic reference model.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int W  = 10;
  localparam int PD = 5;
`ifdef TIMER_RESTART_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vecs  = 0;
  int   errs  = 0;

  always #100 clk = ~clk;

  timer_ctrl_if #(.WIDTH(W)) a_if ();
  timer_ctrl_if #(.WIDTH(W)) b_if ();

  timer_ctrl #(.WIDTH(W), .PRESC_DIV(PD)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if.slave)
  );

  timer_ctrl #(.WIDTH(W), .PRESC_DIV(1)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if.slave)
  );

  task automatic clk1();
    @(posedge clk);
    #1;
    a_if.start = 0; a_if.stop = 0; a_if.irq_clr = 0;
    b_if.start = 0; b_if.stop = 0; b_if.irq_clr = 0;
    #1;
  endtask

  task automatic go_a(input logic m, input logic ud,
                      input logic [W-1:0] p);
    a_if.start = 1; a_if.mode = m;
    a_if.updn = ud; a_if.period = p;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    #250;
    chk("rst_a_status", int'({a_if.busy, a_if.done,
        a_if.irq, a_if.cnt}), 0);
    chk("rst_b_status", int'({b_if.busy, b_if.done,
        b_if.irq, b_if.cnt}), 0);
    @(negedge clk) rst_n = 1;
    clk1();
    b_if.start = 1; b_if.period = 0;
    b_if.mode = ONESHOT; b_if.updn = UP;
    clk1(); clk1(); clk1();
    chk("rst_b_irq_set", int'(b_if.irq), 1);
    go_a(ONESHOT, DOWN, 10'd8);
    clk1(); clk1();
    repeat (15) clk1();
    chk("rst_pre_cnt", int'(a_if.cnt), 5);
    #40 rst_n = 0;
    #1;
    chk("rst_mid_a", int'({a_if.busy, a_if.done,
        a_if.irq, a_if.cnt}), 0);
    chk("rst_mid_b_irq", int'(b_if.irq), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_done", int'(a_if.done), 0);
    end
    rst_n = 1;
    clk1();
    chk("rst_after", int'({a_if.busy, a_if.cnt}), 0);
  endtask

  task automatic test_oneshot_down();
    go_a(ONESHOT, DOWN, 10'd3);
    clk1();
    chk("os_load_busy", int'(a_if.busy), 1);
    clk1();
    for (int r = 0; r < 20; r++) begin
      if (r % 5 == 0) chk("os_cnt", int'(a_if.cnt), 3 - r / 5);
      chk("os_done", int'(a_if.done), int'(r == 19));
      clk1();
    end
    chk("os_end_busy", int'(a_if.busy), 0);
    chk("os_end_irq", int'(a_if.irq), 1);
    repeat (6) clk1();
    chk("os_hold_cnt", int'(a_if.cnt), 0);
  endtask

  task automatic test_periodic_up();
    bit ed;
    bit clr;
    int eirq;
    a_if.irq_clr = 1;
    clk1();
    chk("per_irq_clr", int'(a_if.irq), 0);
    go_a(PERIODIC, UP, 10'd2);
    clk1(); clk1();
    eirq = 0;
    for (int r = 0; r < 45; r++) begin
      clr = (r == 20) || (r == 29);
      a_if.irq_clr = clr;
      #1;
      ed = (r % 15 == 14);
      chk("per_cnt", int'(a_if.cnt), (r / 5) % 3);
      chk("per_done", int'(a_if.done), int'(ed));
      clk1();
      eirq = ed ? 1 : (clr ? 0 : eirq);
      chk("per_irq", int'(a_if.irq), eirq);
    end
    a_if.stop = 1;
    clk1();
    chk("per_stop_busy", int'(a_if.busy), 0);
  endtask

  task automatic test_full_range();
    b_if.start = 1; b_if.period = 10'd1023;
    b_if.mode = ONESHOT; b_if.updn = UP;
    clk1(); clk1();
    for (int r = 0; r < 1024; r++) begin
      chk("fr_cnt", int'(b_if.cnt), r);
      chk("fr_done", int'(b_if.done), int'(r == 1023));
      clk1();
    end
    chk("fr_end_busy", int'(b_if.busy), 0);
    repeat (3) clk1();
    chk("fr_no_wrap", int'(b_if.cnt), 1023);
  endtask

  task automatic test_stop();
    go_a(ONESHOT, DOWN, 10'd10);
    clk1(); clk1();
    repeat (16) clk1();
    chk("stp_cnt7", int'(a_if.cnt), 7);
    a_if.stop = 1; a_if.start = 1; a_if.period = 0;
    #1;
    chk("stp_no_done", int'(a_if.done), 0);
    clk1();
    chk("stp_busy", int'(a_if.busy), 0);
    repeat (7) clk1();
    chk("stp_frozen", int'(a_if.cnt), 7);
    go_a(ONESHOT, DOWN, 10'd0);
    clk1(); clk1();
    for (int r = 0; r < 5; r++) begin
      chk("p0_cnt", int'(a_if.cnt), 0);
      chk("p0_done", int'(a_if.done), int'(r == 4));
      clk1();
    end
    chk("p0_end", int'({a_if.busy, a_if.irq}), 1);
    a_if.irq_clr = 1;
    clk1();
    go_a(ONESHOT, DOWN, 10'd0);
    clk1(); clk1();
    repeat (4) clk1();
    a_if.stop = 1;
    #1;
    chk("stp_tick_done", int'(a_if.done), 0);
    clk1();
    chk("stp_tick_end", int'({a_if.busy, a_if.irq}), 0);
  endtask

  task automatic test_start_busy();
    a_if.irq_clr = 1;
    clk1();
    go_a(PERIODIC, UP, 10'd1);
    clk1(); clk1();
    repeat (9) clk1();
    a_if.start = 1; a_if.period = 10'd9;
    a_if.updn = DOWN; a_if.mode = ONESHOT;
    #1;
`ifdef TIMER_RESTART_EN
    chk("rs_done_supp", int'(a_if.done), 0);
    clk1();
    chk("rs_load", int'({a_if.busy, a_if.irq}), 2);
    chk("rs_cnt_hold", int'(a_if.cnt), 1);
    clk1();
    for (int r = 0; r < 50; r++) begin
      chk("rs_cnt", int'(a_if.cnt), 9 - r / 5);
      chk("rs_done", int'(a_if.done), int'(r == 49));
      clk1();
    end
    chk("rs_end_busy", int'(a_if.busy), 0);
`else
    chk("ign_done", int'(a_if.done), 1);
    clk1();
    chk("ign_busy_irq", int'({a_if.busy, a_if.irq}), 3);
    for (int r = 10; r < 30; r++) begin
      chk("ign_cnt", int'(a_if.cnt), (r / 5) % 2);
      chk("ign_done", int'(a_if.done), int'(r % 10 == 9));
      clk1();
    end
    a_if.stop = 1;
    clk1();
    chk("ign_stop", int'(a_if.busy), 0);
`endif
  endtask

  task automatic test_random();
    int mst, r, mp, ecnt, t, k;
    bit mm, md, mirq, s, st, c, m, u, ed, eb, rs;
    logic [W-1:0] p;
    logic [W+2:0] ev, av;
    rst_n = 0;
    #30;
    @(negedge clk) rst_n = 1;
    mst = 0; r = 0; mp = 0; mm = 0; md = 0;
    mirq = 0; ecnt = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom % 6 == 0);
      st = ($urandom % 40 == 0);
      c  = ($urandom % 10 == 0);
      p  = W'($urandom % 13);
      m  = 1'($urandom);
      u  = 1'($urandom);
      a_if.start = s; a_if.stop = st; a_if.irq_clr = c;
      a_if.period = p; a_if.mode = m; a_if.updn = u;
      #1;
      eb = (mst != 0);
      ed = 0;
      rs = RS_EN && s && !st && (mst != 0);
      if (mst == 2) begin
        t = r / PD;
        k = mm ? t % (mp + 1) : t;
        ecnt = md ? mp - k : k;
        ed = ((r + 1) % PD == 0) &&
             (((r + 1) / PD) % (mp + 1) == 0) && !st && !rs;
      end
      ev = {eb, ed, mirq, W'(ecnt)};
      av = {a_if.busy, a_if.done, a_if.irq, a_if.cnt};
      vecs++;
      if (av !== ev) begin
        errs++;
        $display("FAIL rand_cyc%0d: got %h expected %h",
                 i, av, ev);
      end
      if (st && mst != 0) begin
        mst = 0;
      end else if (s && !st && (mst == 0 || rs)) begin
        mst = 1; mp = int'(p); mm = m; md = u;
      end else if (mst == 1) begin
        mst = 2; r = 0;
      end else if (mst == 2) begin
        if (ed && !mm) begin
          mst = 0; ecnt = md ? 0 : mp;
        end else begin
          r++;
        end
      end
      mirq = ed ? 1'b1 : (c ? 1'b0 : mirq);
      @(posedge clk);
      #1;
    end
    a_if.start = 0; a_if.stop = 0; a_if.irq_clr = 0;
  endtask

  initial begin
    a_if.start = 0; a_if.stop = 0; a_if.mode = 0;
    a_if.updn = 0; a_if.period = '0; a_if.irq_clr = 0;
    b_if.start = 0; b_if.stop = 0; b_if.mode = 0;
    b_if.updn = 0; b_if.period = '0; b_if.irq_clr = 0;
    test_reset();
    test_oneshot_down();
    test_periodic_up();
    test_full_range();
    test_stop();
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable interval timer controller that sequences a 10-bit loadable up/down binary counter (load, en, updn datapath) from a 5 MHz system clock.
- Accepts start/stop commands, latches period/direction/mode, drives load/enable through a prescaler, detects terminal count and raises done pulse plus sticky interrupt.
- Sits between the register/control logic and the counter datapath.

Parameters:
WIDTH, 10, counter and period width in bits
PRESC_DIV, 5, clk cycles per count tick (5 MHz / 5 = 1 MHz tick); legal range 1..256

Ports:
clk  input  1  system clock, 5 MHz, posedge active
rst_n  input  1  asynchronous active-low reset
start  input  1  start request, sampled each cycle
stop  input  1  stop request, sampled each cycle
mode  input  1  0 = one-shot, 1 = periodic auto-reload; latched on accepted start
updn  input  1  0 = count up, 1 = count down; latched on accepted start
period  input  WIDTH  terminal/start value; latched on accepted start
irq_clr  input  1  clears irq
busy  output  1  high in LOAD or RUN
cnt  output  WIDTH  current counter value
done  output  1  one-cycle pulse on terminal-count tick
irq  output  1  sticky interrupt, set by done

Behaviour:
- Reset (async, rst_n=0): state IDLE, cnt=0, prescaler=0, latched regs=0, busy=0, done=0, irq=0. Reset mid-run aborts immediately; no done.
- FSM states:
  - IDLE: start=1 and stop=0 -> latch period/mode/updn -> LOAD. Otherwise hold; cnt holds.
  - LOAD: exactly one cycle. Counter loaded with start value (down: period; up: 0). Prescaler cleared. -> RUN.
  - RUN: prescaler counts 0..PRESC_DIV-1 and wraps. tick = RUN && prescaler==PRESC_DIV-1. Counter enabled only on tick.
- Terminal value: down = 0; up = latched period.
- Tick with cnt == terminal:
  - done=1 for that cycle; irq set.
  - Periodic: counter reloads start value on the same edge; stay RUN.
  - One-shot: counter holds terminal value; -> IDLE.
- Tick otherwise: cnt ±1 per direction.
- Cycle length: period P gives P+1 ticks = (P+1)*PRESC_DIV RUN cycles per done.
- P=0 is legal: done on the first tick.
- No wrap-around occurs in normal operation (terminal reached first).
- Latency:
  - start sampled at edge N -> busy=1 and state LOAD after N.
  - cnt = start value after N+1.
  - First tick on the PRESC_DIV-th RUN cycle.
  - PRESC_DIV=1: tick every RUN cycle.
- stop: in LOAD or RUN -> IDLE on the next edge. cnt frozen, no done. stop beats terminal tick and start in the same cycle.
- start while busy: ignored (see Optional Feature).
- irq: set on done, cleared by irq_clr. Set wins when both occur in the same cycle.
- Latched period/mode/updn are stable while busy; input changes have no effect until the next accepted start.

Optional Feature:
- Macro TIMER_RESTART_EN.
  - Defined: start=1 (stop=0) in LOAD or RUN re-latches period/mode/updn and -> LOAD; pending terminal tick in that cycle is suppressed (no done).
  - Undefined: start ignored while busy.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, LOAD, RUN)
  - default WIDTH and PRESC_DIV constants
  - updn encoding constants (UP=0, DOWN=1)
- One sub-module: cnt_updn, the WIDTH-bit counter datapath with load, en, updn, data_in, cnt.
- timer_ctrl instantiates cnt_updn and contains the FSM, prescaler and irq logic.

Test Plan:
1. Reset asserted mid-RUN (cnt=5, down) -> immediately cnt=0, busy=0, irq=0, state IDLE; no done.
2. WIDTH=10, PRESC_DIV=5, start with period=3, updn=1, mode=0 -> cnt 3,2,1,0 every 5 cycles. done single pulse on 4th tick (20 RUN cycles); irq=1; busy=0 after; cnt holds 0.
3. period=2, updn=0, mode=1 -> cnt 0,1,2,0,1,2… with done every 15 cycles; irq_clr then done in the same cycle -> irq stays 1.
4. period=1023, updn=0, one-shot, PRESC_DIV=1 -> cnt reaches 1023, done after 1024 ticks; no wrap to 0.
5. RUN at cnt=7 down, stop and start together -> IDLE, cnt=7, no done. Later start with period=0 -> done on first tick.
6. start during RUN -> ignored without TIMER_RESTART_EN. With TIMER_RESTART_EN: new period=9 down reloads cnt=9 two edges later; no done.
